// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Bundle for the request side and the response side of mult_share_arbiter.
//   Signals:
//     req_valid[NREQ]   per-requester request valid
//     req_a[4*NREQ]     operand A, requester i at [4i+3:4i]
//     req_b[4*NREQ]     operand B, same packing
//     req_ready[NREQ]   one-hot-or-zero accept strobe
//     rsp_valid         response valid
//     rsp_ready         response consumer ready
//     rsp_product[8]    unsigned a*b
//     rsp_id[IDW]       index of the requester that issued the operation
//     busy              an operation is in flight
//     op_count[16]      completed response handshakes, wraps
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both high. A source keeps valid and its payload
//   stable until the transfer; a requester may withdraw valid before it is
//   accepted, in which case nothing is transferred. ready may depend on valid.
//   modport slave is the arbiter side, modport master is the client side.
`timescale 1ns/1ps
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_product;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [15:0]       op_count;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, busy, op_count
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational 4x4 hybrid compressor multiplier between NREQ
//   requesters. A round-robin arbiter picks one requester per cycle; the
//   operands go through an operand register (stage 1), the multiplier, and a
//   product register (stage 2) that drives the tagged response channel.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mult_share_arbiter_if.slave (request and response channels)
//   Parameters: NREQ (2..8) requesters, IDW = clog2(NREQ) id width.
`timescale 1ns/1ps

// hybrid_compressor_multiplier
//   Unsigned 4x4 -> 8-bit product. The four shifted partial-product rows are
//   reduced per column by a 4:2 compressor (two chained full adders whose
//   first-adder carry feeds the next column's second adder), then the sum and
//   carry vectors are merged by one final adder.
//   Ports: a_i[4], b_i[4] operands; p_o[8] product.
module hybrid_compressor_multiplier (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] pp [4];
  logic [7:0] sum_v;
  logic [7:0] carry_v;

  for (genvar r = 0; r < 4; r++) begin : g_pp
    assign pp[r] = {4'b0000, a_i & {4{b_i[r]}}} << r;
  end

  always_comb begin
    logic s1;
    logic cin;
    logic cout;
    sum_v   = '0;
    carry_v = '0;
    s1      = 1'b0;
    cout    = 1'b0;
    cin     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s1         = pp[0][k] ^ pp[1][k] ^ pp[2][k];
      cout       = (pp[0][k] & pp[1][k]) | (pp[0][k] & pp[2][k]) | (pp[1][k] & pp[2][k]);
      sum_v[k]   = s1 ^ pp[3][k] ^ cin;
      carry_v[k] = (s1 & pp[3][k]) | (s1 & cin) | (pp[3][k] & cin);
      // cout does not depend on cin, so this is not a ripple chain.
      cin        = cout;
    end
  end

  // Weight-2^8 terms are dropped; the true product never exceeds 225.
  assign p_o = sum_v + {carry_v[6:0], 1'b0};
endmodule

module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      s1_a_q, s1_a_d;
  logic [3:0]      s1_b_q, s1_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_product_q, rsp_product_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]     op_count_q, op_count_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [IDW:0]    cand_sum;
  logic [IDW-1:0]  cand_idx;
  logic            out_free;
  logic            accept;
  logic            take;
  logic [7:0]      mult_p;

  // Round-robin search: first asserted request at or after rr_ptr_q, mod NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (cand_sum >= (IDW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      end
      cand_idx = cand_sum[IDW-1:0];
      if (!grant_any && bus.req_valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // Output register can take new data when empty or being drained this cycle;
  // stage 1 can take new data when empty or when it moves on to stage 2.
  assign out_free = !rsp_valid_q || bus.rsp_ready;
  assign accept   = !s1_valid_q || out_free;
  assign take     = grant_any && accept;

  assign bus.req_ready = rst_n ? (grant & {NREQ{accept}}) : '0;

  hybrid_compressor_multiplier u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (mult_p)
  );

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    s1_valid_d    = s1_valid_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_id_d       = s1_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    op_count_d    = op_count_q;

    if (take) begin
      rr_ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      s1_valid_d = 1'b1;
      s1_a_d     = bus.req_a[{grant_idx, 2'b00} +: 4];
      s1_b_d     = bus.req_b[{grant_idx, 2'b00} +: 4];
      s1_id_d    = grant_idx;
    end else if (out_free) begin
      s1_valid_d = 1'b0;
    end

    if (out_free) begin
      rsp_valid_d   = s1_valid_q;
      rsp_product_d = mult_p;
      rsp_id_d      = s1_id_q;
    end

    if (rsp_valid_q && bus.rsp_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_id_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      op_count_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_id_q       <= s1_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
      op_count_q    <= op_count_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = s1_valid_q || rsp_valid_q;
  assign bus.op_count    = op_count_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 8;

  logic clk;
  logic rst_n;

  mult_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];
  int acc_log[$];
  logic [7:0] rq [NREQ][$];   // per-requester pending ops {a,b}
  logic [NREQ-1:0] acc_f;     // accepted at the coming edge
  int exp_count;
  int rsp_seen;
  logic s1_m, rv_m;
  int rr_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int pending();
    int p;
    p = exp_q.size() + (bus.busy ? 1 : 0);
    for (int i = 0; i < NREQ; i++) p += rq[i].size();
    return p;
  endfunction

  // ---------------- requester driver ----------------
  initial begin
    logic [7:0] head;
    logic [7:0] dropped;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_f[i] && rq[i].size() > 0) dropped = rq[i].pop_front();
        if (rq[i].size() > 0) begin
          head = rq[i][0];
          bus.req_valid[i]     = 1'b1;
          bus.req_a[4*i +: 4]  = head[7:4];
          bus.req_b[4*i +: 4]  = head[3:0];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic of, acc_m;
    logic [W-1:0] e;
    logic [7:0] ea, eb;
    acc_f = '0; s1_m = 1'b0; rv_m = 1'b0; rr_m = 0;
    exp_count = 0; rsp_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_f = '0; s1_m = 1'b0; rv_m = 1'b0; rr_m = 0;
        exp_q.delete();
        exp_count = 0;
      end else begin
        g     = rr_pick(bus.req_valid, rr_m);
        of    = !rv_m || bus.rsp_ready;
        acc_m = !s1_m || of;
        exp_rdy = '0;
        if (g >= 0 && acc_m) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(rv_m));
        check("busy", 32'(bus.busy), 32'(s1_m || rv_m));

        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_seen++;
          exp_count = (exp_count + 1) % 65536;
          if (exp_q.size() == 0) begin
            check("rsp_without_request", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id_product", 32'({bus.rsp_id, bus.rsp_product}), 32'(e));
          end
        end

        acc_f = bus.req_valid & bus.req_ready;
        for (int i = 0; i < NREQ; i++) begin
          if (acc_f[i]) begin
            ea = {4'b0000, bus.req_a[4*i +: 4]};
            eb = {4'b0000, bus.req_b[4*i +: 4]};
            exp_q.push_back({IDW'(i), 8'(ea * eb)});
            acc_log.push_back(i);
          end
        end

        if (of) rv_m = s1_m;
        if (g >= 0 && acc_m) begin
          s1_m = 1'b1;
          rr_m = (g + 1) % NREQ;
        end else if (of) begin
          s1_m = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rsp(input logic v);
    @(posedge clk);
    #1;
    bus.rsp_ready = v;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (pending() != 0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (pending() != 0) check("drain_timeout", 32'(pending()), 32'd0);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int c;
    c = 0;
    while (acc_log.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (acc_log.size() < n) check("accept_timeout", 32'(acc_log.size()), 32'(n));
  endtask

  task automatic wait_exp(input int n, input int budget);
    int c;
    c = 0;
    while (exp_q.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (exp_q.size() < n) check("fill_timeout", 32'(exp_q.size()), 32'(n));
  endtask

  task automatic drain_random(input int budget);
    int c;
    c = 0;
    while (pending() != 0 && c < budget) begin
      @(posedge clk); #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      c++;
    end
    set_rsp(1'b1);
    wait_idle(50);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c, base, n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_product", 32'(bus.rsp_product), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_op_count", 32'(bus.op_count), 32'd0);

    // Fairness: all requesters valid out of reset, operands (i, i+1)
    for (int i = 0; i < NREQ; i++) rq[i].push_back({4'(i), 4'(i + 1)});
    rq[0].push_back({4'd0, 4'd1});
    @(negedge clk); #1;
    check("reset_req_ready_forced", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_acc(5, 40);
    for (int k = 0; k < 5; k++) begin
      if (k < acc_log.size()) check("fair_order", 32'(acc_log[k]), 32'(k % NREQ));
    end
    wait_idle(100);
    check("fair_op_count", 32'(bus.op_count), 32'd5);

    // Single request, latency
    acc_log.delete();
    base = exp_count;
    rq[2].push_back({4'd9, 4'd13});
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!bus.req_ready[2] && c < 20);
    check("single_ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk); #1;
    check("single_ready_drop", 32'(bus.req_ready), 32'd0);
    check("single_not_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); #1;
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_product", 32'(bus.rsp_product), 32'd117);
    check("single_id", 32'(bus.rsp_id), 32'd2);
    @(negedge clk); #1;
    check("single_op_count", 32'(bus.op_count), 32'((base + 1) % 65536));
    wait_idle(20);

    // Backpressure
    set_rsp(1'b0);
    base = rsp_seen;
    for (int k = 0; k < 3; k++) rq[0].push_back({4'd15, 4'd15});
    wait_exp(2, 20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      check("bp_product_held", 32'(bus.rsp_product), 32'd225);
      check("bp_id_held", 32'(bus.rsp_id), 32'd0);
    end
    check("bp_buffered", 32'(exp_q.size()), 32'd2);
    set_rsp(1'b1);
    wait_idle(30);
    check("bp_rsp_total", 32'(rsp_seen - base), 32'd3);

    // Boundaries and exhaustive through requester 1, with traffic elsewhere
    rq[1].push_back({4'd0, 4'd15});
    rq[1].push_back({4'd15, 4'd1});
    rq[1].push_back({4'd8, 4'd8});
    for (int p = 0; p < 256; p++) rq[1].push_back(8'(p));
    for (int k = 0; k < 40; k++) begin
      rq[0].push_back(8'($urandom_range(0, 255)));
      rq[2].push_back(8'($urandom_range(0, 255)));
      rq[3].push_back(8'($urandom_range(0, 255)));
    end
    drain_random(3000);

    // Reset in the middle of a full pipe
    set_rsp(1'b0);
    for (int k = 0; k < 3; k++) rq[2].push_back({4'd7, 4'd11});
    wait_exp(2, 20);
    @(negedge clk); #1;
    check("midrst_full", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_op_count", 32'(bus.op_count), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    rq[3].push_back({4'd1, 4'd2});
    rq[1].push_back({4'd3, 4'd4});
    acc_log.delete();
    set_rsp(1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_acc(1, 20);
    if (acc_log.size() > 0) check("midrst_first_grant", 32'(acc_log[0]), 32'd1);
    wait_idle(30);
    check("midrst_op_count_after", 32'(bus.op_count), 32'(exp_count));

    // Counter wrap
    n = 65536 - exp_count;
    for (int k = 0; k < n; k++) rq[0].push_back(8'($urandom_range(0, 255)));
    wait_idle(70000);
    check("wrap_op_count_zero", 32'(bus.op_count), 32'h0000);
    check("wrap_op_count_model", 32'(bus.op_count), 32'(exp_count));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Shares one 4x4 hybrid compressor multiplier (combinational, 8-bit product) between NREQ independent requesters. A round-robin arbiter grants one requester per cycle. A 2-stage pipeline (operand register, product register) surrounds the shared datapath. Products return on a single tagged response channel with valid/ready backpressure. The block sits between the multiply clients and the `hybrid_compressor_multiplier` instance it owns.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-ID width; must equal clog2(NREQ)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, rising-edge clock.
  - rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NREQ, per-requester request valid.
- req_a, input, 4*NREQ, operand A; requester i uses bits [4i+3:4i].
- req_b, input, 4*NREQ, operand B; same packing as req_a.
- req_ready, output, NREQ, one-hot-or-zero accept strobe.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumer ready.
- rsp_product, output, 8, product a*b, unsigned.
- rsp_id, output, IDW, index of the requester that issued the operation.
- busy, output, 1, high when any operation is in flight (s1_valid | rsp_valid).
- op_count, output, 16, count of completed response handshakes; wraps.

## Operation
- Requester handshake:
  - Request i is accepted when req_valid[i] & req_ready[i].
  - The requester holds valid and operands stable until accepted.
  - Dropping valid before acceptance is allowed; the request is then simply not serviced.
- Arbitration:
  - Round-robin pointer rr_ptr (IDW bits).
  - The grant goes to the first asserted req_valid at or after rr_ptr, wrapping modulo NREQ.
  - On an accepted request, rr_ptr ← granted index + 1 (mod NREQ). Otherwise rr_ptr holds.
- Pipeline control:
  - out_free = !rsp_valid | rsp_ready.
  - accept = !s1_valid | out_free.
  - req_ready[i] = grant[i] & accept. At most one bit is high.
- Stage 1 (operand register):
  - On an accept with a granted request, capture a, b and id, and set s1_valid.
  - Else, if out_free, clear s1_valid. Else hold.
- Stage 2 (output register):
  - When out_free: load rsp_product ← mult(s1_a, s1_b), rsp_id ← s1_id, rsp_valid ← s1_valid.
  - Otherwise hold all response outputs unchanged.
- Arithmetic: unsigned 4x4 → 8-bit. There is no overflow; maximum is 15*15 = 225.
- op_count:
  - Increments by 1 on every rsp_valid & rsp_ready.
  - 0xFFFF wraps to 0x0000.
- Reset, including mid-operation:
  - All in-flight operations are discarded and rr_ptr = 0.
  - Reset values: rsp_valid=0, rsp_product=0x00, rsp_id=0, busy=0, op_count=0, s1_valid=0.
  - req_ready is forced to 0 while rst_n is low.
- Simultaneous events:
  - An accept and a response handshake in the same cycle are both honoured. Full throughput is 1 operation per cycle.
  - A new request arriving while the pipe is full is not accepted until out_free.

## Timing
- Accept at edge N → s1 loaded after N → rsp_valid high in the cycle after edge N+1. Latency is 2 cycles from acceptance.
- With rsp_ready held high, back-to-back accepts produce back-to-back responses, one per cycle, in acceptance order.
- While rsp_valid=1 and rsp_ready=0:
  - rsp_product and rsp_id hold stable.
  - s1 holds.
  - req_ready stays high only while s1 is empty, so at most 2 operations are buffered.
- The grant is combinational from req_valid and rr_ptr. There is no combinational path from rsp_ready to rsp_valid or rsp_product.
- Asynchronous reset assertion clears state immediately. Deassertion is synchronous to clk; the first accept is possible on the first rising edge after deassertion.

## Test plan
- Single request: req 2 with a=9, b=13, rsp_ready=1 → req_ready[2] high one cycle. Two cycles later rsp_valid=1, rsp_product=117 (0x75), rsp_id=2, op_count=1.
- Fairness: all 4 requesters hold valid with distinct operands (i, i+1) from reset → accepts in order 0,1,2,3,0. Responses arrive on consecutive cycles with products 0, 2, 6, 12 and matching ids.
- Backpressure: requester 0 streams a=15, b=15 with rsp_ready low for 3 cycles → rsp_product=225 held stable. After 2 accepts, req_ready drops to 0. Releasing rsp_ready gives 2 back-to-back responses with no loss or duplication.
- Boundaries: a=0, b=15 → 0. a=15, b=1 → 15. a=8, b=8 → 64. Check exhaustively: all 256 operand pairs through requester 1 match a*b.
- Reset mid-operation: assert rst_n low with s1 and the output register full → rsp_valid=0, busy=0, op_count=0 immediately. After release, the next grant goes to the lowest-index valid requester.
- Counter wrap: force 65536 response handshakes → op_count returns to 0x0000. The handshake that wraps the counter still produces a correct product.
